mem_wport_arbiter: RTL and testbench

//  Shares the memory's single write port and read port 1 between two requesters
//  (req 0 = processor load/store, req 1 = loader/debug DMA). Read port 0 stays with

---
 rtl/mem_wport_arbiter.sv | 175 +++++++++++++++++
 tb/tb_mem_wport_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wport_arbiter.sv
// Round-robin arbiter sharing the memory write port and read port 1 between two
// requesters, with locked bursts, registered read responses and an address-range check.
module mem_wport_arbiter #(
    parameter int N_ELEMENTS = 128,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_BURST  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_0,
    input  logic                  req_we_0,
    input  logic                  req_lock_0,
    input  logic [ADDR_WIDTH-1:0] req_addr_0,
    input  logic [DATA_WIDTH-1:0] req_wdata_0,
    output logic                  req_ready_0,
    output logic                  rsp_valid_0,
    output logic [DATA_WIDTH-1:0] rsp_data_0,
    output logic                  rsp_err_0,
    input  logic                  req_valid_1,
    input  logic                  req_we_1,
    input  logic                  req_lock_1,
    input  logic [ADDR_WIDTH-1:0] req_addr_1,
    input  logic [DATA_WIDTH-1:0] req_wdata_1,
    output logic                  req_ready_1,
    output logic                  rsp_valid_1,
    output logic [DATA_WIDTH-1:0] rsp_data_1,
    output logic                  rsp_err_1,
    output logic [ADDR_WIDTH-1:0] mem_r_addr,
    input  logic [DATA_WIDTH-1:0] mem_r_data,
    output logic [ADDR_WIDTH-1:0] mem_w_addr,
    output logic [DATA_WIDTH-1:0] mem_w_data,
    output logic                  mem_w_en
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    localparam logic [1:0] ST_NONE  = 2'd0;
    localparam logic [1:0] ST_LOCK0 = 2'd1;
    localparam logic [1:0] ST_LOCK1 = 2'd2;

    logic [1:0]            r_state;
    logic                  r_last_grant;
    logic [CNT_W-1:0]      r_burst_cnt;

    logic                  r_rsp_valid_0;
    logic                  r_rsp_err_0;
    logic [DATA_WIDTH-1:0] r_rsp_data_0;
    logic                  r_rsp_valid_1;
    logic                  r_rsp_err_1;
    logic [DATA_WIDTH-1:0] r_rsp_data_1;

    logic                  w_gnt_any;
    logic                  w_gnt_id;
    logic                  w_valid;
    logic                  w_we;
    logic                  w_lock;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic                  w_xfer;
    logic                  w_xfer_0;
    logic                  w_xfer_1;
    logic                  w_in_range;
    logic [CNT_W-1:0]      w_cnt_next;
    logic                  w_burst_done;

    // Owner keeps the grant while locked; otherwise the requester that did not win last goes first.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_id  = 1'b0;
        case (r_state)
            ST_LOCK0: begin
                w_gnt_any = 1'b1;
                w_gnt_id  = 1'b0;
            end
            ST_LOCK1: begin
                w_gnt_any = 1'b1;
                w_gnt_id  = 1'b1;
            end
            default: begin
                w_gnt_any = req_valid_0 | req_valid_1;
                if (req_valid_0 && req_valid_1)
                    w_gnt_id = ~r_last_grant;
                else
                    w_gnt_id = req_valid_1;
            end
        endcase
        if (!rst)
            w_gnt_any = 1'b0;
    end

    assign req_ready_0 = w_gnt_any & ~w_gnt_id;
    assign req_ready_1 = w_gnt_any &  w_gnt_id;

    assign w_valid = w_gnt_id ? req_valid_1 : req_valid_0;
    assign w_we    = w_gnt_id ? req_we_1    : req_we_0;
    assign w_lock  = w_gnt_id ? req_lock_1  : req_lock_0;
    assign w_addr  = w_gnt_id ? req_addr_1  : req_addr_0;
    assign w_wdata = w_gnt_id ? req_wdata_1 : req_wdata_0;

    assign w_xfer   = w_gnt_any & w_valid;
    assign w_xfer_0 = w_xfer & ~w_gnt_id;
    assign w_xfer_1 = w_xfer &  w_gnt_id;

    assign w_in_range   = ({1'b0, w_addr} < (ADDR_WIDTH + 1)'(N_ELEMENTS));
    assign w_cnt_next   = r_burst_cnt + 1'b1;
    assign w_burst_done = (w_cnt_next == CNT_W'(MAX_BURST));

    assign mem_r_addr = w_addr;
    assign mem_w_addr = w_addr;
    assign mem_w_data = w_wdata;
    assign mem_w_en   = w_xfer & w_we & w_in_range;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_NONE;
            r_last_grant <= 1'b1;
            r_burst_cnt  <= '0;
        end else begin
            if (w_xfer)
                r_last_grant <= w_gnt_id;
            case (r_state)
                ST_LOCK0, ST_LOCK1: begin
                    if (!w_valid || !w_lock) begin
                        r_state     <= ST_NONE;
                        r_burst_cnt <= '0;
                    end else if (w_burst_done) begin
                        r_state     <= ST_NONE;
                        r_burst_cnt <= '0;
                    end else begin
                        r_burst_cnt <= w_cnt_next;
                    end
                end
                default: begin
                    if (w_xfer && w_lock && (MAX_BURST > 1)) begin
                        r_state     <= w_gnt_id ? ST_LOCK1 : ST_LOCK0;
                        r_burst_cnt <= CNT_W'(1);
                    end else begin
                        r_state     <= ST_NONE;
                        r_burst_cnt <= '0;
                    end
                end
            endcase
        end
    end

    // Read data is captured at the transfer edge, so it reflects memory before any write there.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rsp_valid_0 <= 1'b0;
            r_rsp_err_0   <= 1'b0;
            r_rsp_data_0  <= '0;
            r_rsp_valid_1 <= 1'b0;
            r_rsp_err_1   <= 1'b0;
            r_rsp_data_1  <= '0;
        end else begin
            r_rsp_valid_0 <= w_xfer_0 & ~w_we;
            r_rsp_err_0   <= w_xfer_0 & ~w_in_range;
            if (w_xfer_0 && !w_we)
                r_rsp_data_0 <= w_in_range ? mem_r_data : '0;
            r_rsp_valid_1 <= w_xfer_1 & ~w_we;
            r_rsp_err_1   <= w_xfer_1 & ~w_in_range;
            if (w_xfer_1 && !w_we)
                r_rsp_data_1 <= w_in_range ? mem_r_data : '0;
        end
    end

    assign rsp_valid_0 = r_rsp_valid_0;
    assign rsp_err_0   = r_rsp_err_0;
    assign rsp_data_0  = r_rsp_data_0;
    assign rsp_valid_1 = r_rsp_valid_1;
    assign rsp_err_1   = r_rsp_err_1;
    assign rsp_data_1  = r_rsp_data_1;

endmodule

// File: tb/tb_mem_wport_arbiter.sv
// Directed bench for mem_wport_arbiter with a small behavioural memory on the shared ports.
module tb_mem_wport_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          preload;
    logic          req_valid_0, req_we_0, req_lock_0;
    logic [AW-1:0] req_addr_0;
    logic [DW-1:0] req_wdata_0;
    logic          req_ready_0, rsp_valid_0, rsp_err_0;
    logic [DW-1:0] rsp_data_0;
    logic          req_valid_1, req_we_1, req_lock_1;
    logic [AW-1:0] req_addr_1;
    logic [DW-1:0] req_wdata_1;
    logic          req_ready_1, rsp_valid_1, rsp_err_1;
    logic [DW-1:0] rsp_data_1;
    logic [AW-1:0] mem_r_addr, mem_w_addr;
    logic [DW-1:0] mem_r_data, mem_w_data;
    logic          mem_w_en;

    logic [DW-1:0] mem [0:127];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_wport_arbiter dut (
        .clk(clk), .rst(rst),
        .req_valid_0(req_valid_0), .req_we_0(req_we_0), .req_lock_0(req_lock_0),
        .req_addr_0(req_addr_0), .req_wdata_0(req_wdata_0), .req_ready_0(req_ready_0),
        .rsp_valid_0(rsp_valid_0), .rsp_data_0(rsp_data_0), .rsp_err_0(rsp_err_0),
        .req_valid_1(req_valid_1), .req_we_1(req_we_1), .req_lock_1(req_lock_1),
        .req_addr_1(req_addr_1), .req_wdata_1(req_wdata_1), .req_ready_1(req_ready_1),
        .rsp_valid_1(rsp_valid_1), .rsp_data_1(rsp_data_1), .rsp_err_1(rsp_err_1),
        .mem_r_addr(mem_r_addr), .mem_r_data(mem_r_data),
        .mem_w_addr(mem_w_addr), .mem_w_data(mem_w_data), .mem_w_en(mem_w_en)
    );

    always_comb begin
        mem_r_data = '0;
        if (mem_r_addr < 16'd128)
            mem_r_data = mem[mem_r_addr[6:0]];
    end

    always @(posedge clk) begin
        if (preload) begin
            mem[5] <= 16'h1111;
            mem[6] <= 16'h2222;
        end else if (mem_w_en && mem_w_addr < 16'd128) begin
            mem[mem_w_addr[6:0]] <= mem_w_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drv0(input logic v, input logic we, input logic lk,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid_0 = v; req_we_0 = we; req_lock_0 = lk; req_addr_0 = a; req_wdata_0 = d;
    endtask

    task automatic drv1(input logic v, input logic we, input logic lk,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid_1 = v; req_we_1 = we; req_lock_1 = lk; req_addr_1 = a; req_wdata_1 = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        preload = 1'b1;
        drv0(1'b1, 1'b0, 1'b0, 16'd5, 16'h0);
        drv1(1'b0, 1'b0, 1'b0, 16'd0, 16'h0);
        @(posedge clk); @(posedge clk); #1;
        chk("rst_ready0", req_ready_0, 1'b0);
        chk("rst_ready1", req_ready_1, 1'b0);
        chk("rst_wen", mem_w_en, 1'b0);
        chk("rst_rspv0", rsp_valid_0, 1'b0);
        chk("rst_rspv1", rsp_valid_1, 1'b0);
        chk("rst_err0", rsp_err_0, 1'b0);
        chk("rst_data0", rsp_data_0, 16'h0);

        // Round-robin: both read, req0 first because last_grant resets to 1
        @(negedge clk);
        rst = 1'b1; preload = 1'b0;
        drv0(1'b1, 1'b0, 1'b0, 16'd5, 16'h0);
        drv1(1'b1, 1'b0, 1'b0, 16'd6, 16'h0);
        #1;
        chk("rr_c1_ready0", req_ready_0, 1'b1);
        chk("rr_c1_ready1", req_ready_1, 1'b0);
        chk("rr_c1_raddr", mem_r_addr, 16'd5);
        @(posedge clk); #1;
        chk("rr_rspv0", rsp_valid_0, 1'b1);
        chk("rr_rspd0", rsp_data_0, 16'h1111);
        chk("rr_rspv1_early", rsp_valid_1, 1'b0);
        @(negedge clk);
        drv0(1'b0, 1'b0, 1'b0, 16'd0, 16'h0);
        #1;
        chk("rr_c2_ready1", req_ready_1, 1'b1);
        chk("rr_c2_ready0", req_ready_0, 1'b0);
        chk("rr_c2_raddr", mem_r_addr, 16'd6);
        @(posedge clk); #1;
        chk("rr_rspv1", rsp_valid_1, 1'b1);
        chk("rr_rspd1", rsp_data_1, 16'h2222);
        chk("rr_rspv0_drop", rsp_valid_0, 1'b0);
        chk("rr_rspd0_hold", rsp_data_0, 16'h1111);
        @(negedge clk);
        drv1(1'b0, 1'b0, 1'b0, 16'd0, 16'h0);

        // Locked burst by req1, limited to 8 transfers while req0 waits
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drv1(1'b1, 1'b1, 1'b1, 16'h40 + 16'(i), 16'h1040 + 16'(i));
            if (i == 1)
                drv0(1'b1, 1'b0, 1'b0, 16'h40, 16'h0);
            #1;
            chk($sformatf("burst%0d_ready1", i), req_ready_1, 1'b1);
            chk($sformatf("burst%0d_ready0", i), req_ready_0, 1'b0);
            chk($sformatf("burst%0d_wen", i), mem_w_en, 1'b1);
            chk($sformatf("burst%0d_waddr", i), mem_w_addr, 16'h40 + 16'(i));
            @(posedge clk);
        end
        @(negedge clk);
        drv1(1'b1, 1'b1, 1'b1, 16'h48, 16'h1048);
        #1;
        chk("burst9_ready0", req_ready_0, 1'b1);
        chk("burst9_ready1", req_ready_1, 1'b0);
        chk("burst9_wen", mem_w_en, 1'b0);
        @(posedge clk); #1;
        chk("burst9_rspv0", rsp_valid_0, 1'b1);
        chk("burst9_rspd0", rsp_data_0, 16'h1040);
        for (int i = 8; i < 12; i++) begin
            @(negedge clk);
            drv0(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
            drv1(1'b1, 1'b1, (i != 11), 16'h40 + 16'(i), 16'h1040 + 16'(i));
            #1;
            chk($sformatf("burst%0d_ready1", i), req_ready_1, 1'b1);
            chk($sformatf("burst%0d_wen", i), mem_w_en, 1'b1);
            @(posedge clk);
        end
        @(negedge clk);
        drv1(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        #1;
        chk("burst_idle_ready1", req_ready_1, 1'b0);
        chk("burst_mem47", mem[7'h47], 16'h1047);
        chk("burst_mem4b", mem[7'h4B], 16'h104B);

        // Write then read back in range
        drv0(1'b1, 1'b1, 1'b0, 16'h0030, 16'hBEEF);
        #1;
        chk("wr30_ready0", req_ready_0, 1'b1);
        chk("wr30_wen", mem_w_en, 1'b1);
        chk("wr30_waddr", mem_w_addr, 16'h0030);
        chk("wr30_wdata", mem_w_data, 16'hBEEF);
        @(posedge clk); #1;
        chk("wr30_err0", rsp_err_0, 1'b0);
        chk("wr30_rspv0", rsp_valid_0, 1'b0);
        @(negedge clk);
        drv0(1'b1, 1'b0, 1'b0, 16'h0030, 16'h0);
        #1;
        chk("rd30_ready0", req_ready_0, 1'b1);
        @(posedge clk); #1;
        chk("rd30_rspv0", rsp_valid_0, 1'b1);
        chk("rd30_rspd0", rsp_data_0, 16'hBEEF);
        chk("rd30_err0", rsp_err_0, 1'b0);
        @(negedge clk);
        drv0(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);

        // Out-of-range write and read by req1
        drv1(1'b1, 1'b1, 1'b0, 16'd200, 16'h5555);
        #1;
        chk("oor_wr_ready1", req_ready_1, 1'b1);
        chk("oor_wr_wen", mem_w_en, 1'b0);
        @(posedge clk); #1;
        chk("oor_wr_err1", rsp_err_1, 1'b1);
        chk("oor_wr_rspv1", rsp_valid_1, 1'b0);
        @(negedge clk);
        drv1(1'b1, 1'b0, 1'b0, 16'd200, 16'h0);
        #1;
        chk("oor_rd_ready1", req_ready_1, 1'b1);
        @(posedge clk); #1;
        chk("oor_rd_rspv1", rsp_valid_1, 1'b1);
        chk("oor_rd_rspd1", rsp_data_1, 16'h0);
        chk("oor_rd_err1", rsp_err_1, 1'b1);
        @(negedge clk);
        drv1(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        @(posedge clk); #1;
        chk("oor_idle_rspv1", rsp_valid_1, 1'b0);
        chk("oor_idle_err1", rsp_err_1, 1'b0);

        // Asynchronous reset in the middle of a req1 locked burst
        @(negedge clk);
        drv1(1'b1, 1'b0, 1'b1, 16'd5, 16'h0);
        #1;
        chk("mrst_c1_ready1", req_ready_1, 1'b1);
        @(negedge clk);
        drv0(1'b1, 1'b0, 1'b0, 16'd6, 16'h0);
        drv1(1'b1, 1'b0, 1'b1, 16'd6, 16'h0);
        #1;
        chk("mrst_c2_ready1", req_ready_1, 1'b1);
        chk("mrst_c2_ready0", req_ready_0, 1'b0);
        @(posedge clk); #1;
        chk("mrst_rspv1", rsp_valid_1, 1'b1);
        chk("mrst_rspd1", rsp_data_1, 16'h2222);
        drv1(1'b1, 1'b1, 1'b1, 16'h50, 16'hAAAA);
        #1;
        chk("mrst_pre_wen", mem_w_en, 1'b1);
        rst = 1'b0;
        #1;
        chk("mrst_ready1", req_ready_1, 1'b0);
        chk("mrst_ready0", req_ready_0, 1'b0);
        chk("mrst_wen", mem_w_en, 1'b0);
        chk("mrst_rspv1_clr", rsp_valid_1, 1'b0);
        chk("mrst_rspd1_clr", rsp_data_1, 16'h0);
        @(negedge clk);
        rst = 1'b1;
        drv0(1'b1, 1'b0, 1'b0, 16'd5, 16'h0);
        drv1(1'b1, 1'b0, 1'b0, 16'd6, 16'h0);
        #1;
        chk("post_rst_ready0", req_ready_0, 1'b1);
        chk("post_rst_ready1", req_ready_1, 1'b0);
        @(posedge clk); #1;
        chk("post_rst_rspv0", rsp_valid_0, 1'b1);
        chk("post_rst_rspd0", rsp_data_0, 16'h1111);
        chk("post_rst_rspv1", rsp_valid_1, 1'b0);
        @(negedge clk);
        drv0(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        #1;
        chk("post_rst_c2_ready1", req_ready_1, 1'b1);
        @(negedge clk);
        drv1(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
